// File: rtl/acc_pkg.sv
// Shared types and helpers for the acc_array multi-lane accumulator.
// Optional saturation arithmetic is built when ACC_SAT_EN is defined.
package acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Helpers work at a fixed wide width; callers size-cast the result down.
    localparam int unsigned ACC_MAX_W = 128;

    function automatic logic [ACC_MAX_W-1:0] sext_w(input logic [ACC_MAX_W-1:0] v,
                                                    input int unsigned          from_w);
        logic [ACC_MAX_W-1:0] r;
        r = v << (ACC_MAX_W - from_w);
        return $signed(r) >>> (ACC_MAX_W - from_w);
    endfunction

    function automatic logic [ACC_MAX_W-1:0] sat_max(input int unsigned w);
        return (ACC_MAX_W'(1) << (w - 1)) - ACC_MAX_W'(1);
    endfunction

    function automatic logic [ACC_MAX_W-1:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulation lane: accumulator register plus sticky saturation flag.
// Saturating add and the sat port exist only when ACC_SAT_EN is defined.
module acc_lane
    import acc_pkg::*;
#(
    parameter int unsigned D_W_ACC = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               add_i,
    input  logic [D_W_ACC-1:0] data_i,
`ifdef ACC_SAT_EN
    output logic               sat_o,
`endif
    output logic [D_W_ACC-1:0] next_o
);

    logic [D_W_ACC-1:0] acc_q;
    logic [D_W_ACC-1:0] sum;
    logic [D_W_ACC-1:0] add_val;

    assign sum = acc_q + data_i;

`ifdef ACC_SAT_EN
    localparam logic [D_W_ACC-1:0] SAT_MAX = D_W_ACC'(sat_max(D_W_ACC));
    localparam logic [D_W_ACC-1:0] SAT_MIN = D_W_ACC'(sat_min(D_W_ACC));

    logic ovf;
    logic sat_q;
    logic sat_d;

    // Overflow only possible when both operands share a sign the sum lacks.
    always_comb begin
        ovf     = (acc_q[D_W_ACC-1] == data_i[D_W_ACC-1]) &&
                  (sum[D_W_ACC-1] != acc_q[D_W_ACC-1]);
        add_val = ovf ? (acc_q[D_W_ACC-1] ? SAT_MIN : SAT_MAX) : sum;
        sat_d   = start_i ? 1'b0 : (sat_q | ovf);
    end

    assign sat_o = sat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (start_i || add_i) begin
            sat_q <= sat_d;
        end
    end
`else
    assign add_val = sum;
`endif

    assign next_o = start_i ? data_i : add_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (start_i || add_i) begin
            acc_q <= next_o;
        end
    end

endmodule

// File: rtl/acc_array.sv
// Multi-lane framed streaming accumulator with a one-deep valid/ready result register.
// Define ACC_SAT_EN for saturating lane adds and per-lane sticky out_sat flags.
module acc_array
    import acc_pkg::*;
#(
    parameter int unsigned LANES   = 4,
    parameter int unsigned D_W     = 32,
    parameter int unsigned D_W_ACC = 40,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*D_W-1:0]     in_data,
    input  logic                     in_first,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*D_W_ACC-1:0] out_data,
    output logic [CNT_W-1:0]         out_count,
    output logic [LANES-1:0]         out_sat
);

    state_e                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic                     out_valid_q;
    logic [LANES*D_W_ACC-1:0] out_data_q;
    logic [CNT_W-1:0]         out_count_q;
    logic [LANES*D_W_ACC-1:0] next_vec;
    logic                     accept;
    logic                     start;
    logic                     add;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // IDLE implies a frame start even when in_first is low.
    assign start    = accept && ((state_q == IDLE) || in_first);
    assign add      = accept && !start;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef ACC_SAT_EN
    logic [LANES-1:0] sat_vec;
    logic [LANES-1:0] out_sat_q;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [D_W_ACC-1:0] lane_data;

        assign lane_data = D_W_ACC'(sext_w(ACC_MAX_W'(in_data[g*D_W +: D_W]), D_W));

        acc_lane #(
            .D_W_ACC (D_W_ACC)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .start_i (start),
            .add_i   (add),
            .data_i  (lane_data),
`ifdef ACC_SAT_EN
            .sat_o   (sat_vec[g]),
`endif
            .next_o  (next_vec[g*D_W_ACC +: D_W_ACC])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
`ifdef ACC_SAT_EN
            out_sat_q   <= '0;
`endif
        end else begin
            if (accept) begin
                cnt_q   <= cnt_d;
                state_q <= in_last ? IDLE : ACCUM;
            end
            // The closing beat's freshly computed sums go straight to the result.
            if (accept && in_last) begin
                out_valid_q <= 1'b1;
                out_data_q  <= next_vec;
                out_count_q <= cnt_d;
`ifdef ACC_SAT_EN
                out_sat_q   <= sat_vec;
`endif
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
`ifdef ACC_SAT_EN
    assign out_sat   = out_sat_q;
`else
    assign out_sat   = '0;
`endif

endmodule

// File: tb/tb_acc_array.sv
// Directed bench for acc_array (LANES=4, D_W=32, D_W_ACC=40); expectations follow ACC_SAT_EN.
module tb_acc_array;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DWA   = 40;
    localparam int unsigned CW    = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*DW-1:0]  in_data;
    logic                 in_first;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*DWA-1:0] out_data;
    logic [CW-1:0]        out_count;
    logic [LANES-1:0]     out_sat;

    int checks = 0;
    int errors = 0;

    acc_array #(
        .LANES   (LANES),
        .D_W     (DW),
        .D_W_ACC (DWA),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic                 v;
        logic                 f;
        logic                 l;
        logic [LANES*DW-1:0]  din;
        logic                 exp_ov;
        logic                 chk;
        logic [LANES*DWA-1:0] exp_data;
        logic [CW-1:0]        exp_cnt;
    } vec_t;

    function automatic logic [LANES*DW-1:0] din4(input logic signed [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [LANES*DWA-1:0] dout4(input logic signed [DWA-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic l, input logic [LANES*DW-1:0] d);
        in_valid = v;
        in_first = f;
        in_last  = l;
        in_data  = d;
    endtask

    vec_t             tbl[11];
    logic [63:0]      wide;
    logic [DWA-1:0]   exp_lane0;
    logic [LANES-1:0] exp_sat;

    initial begin
        tbl[0]  = '{1, 1, 0, din4(5, 0, 1, -1),   0, 0, '0, 0};
        tbl[1]  = '{1, 0, 0, din4(-2, 0, 1, -1),  0, 0, '0, 0};
        tbl[2]  = '{1, 0, 1, din4(10, 0, 1, -1),  1, 1, dout4(13, 0, 3, -3), 3};
        tbl[3]  = '{0, 0, 1, din4(99, 99, 99, 99), 0, 1, dout4(13, 0, 3, -3), 3};
        tbl[4]  = '{1, 1, 1, din4(0, -7, 0, 0),   1, 1, dout4(0, -7, 0, 0), 1};
        tbl[5]  = '{1, 0, 0, din4(100, 0, 0, 0),  0, 0, '0, 0};
        tbl[6]  = '{1, 1, 0, din4(3, 0, 0, 0),    0, 0, '0, 0};
        tbl[7]  = '{1, 0, 1, din4(4, 0, 0, 0),    1, 1, dout4(7, 0, 0, 0), 2};
        tbl[8]  = '{1, 1, 1, din4(32'sh8000_0000, 32'sh7FFF_FFFF, 0, 0), 1, 1,
                    dout4(32'sh8000_0000, 32'sh7FFF_FFFF, 0, 0), 1};
        tbl[9]  = '{1, 0, 0, din4(1, 2, 3, 4),    0, 0, '0, 0};
        tbl[10] = '{1, 0, 1, din4(-1, -2, -3, -4), 1, 1, dout4(0, 0, 0, 0), 2};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 0, '0);
        repeat (2) @(negedge clk);
        check("reset_out_valid", 160'(out_valid), 160'(0));
        check("reset_out_data",  160'(out_data),  160'(0));
        check("reset_out_count", 160'(out_count), 160'(0));
        check("reset_out_sat",   160'(out_sat),   160'(0));
        check("reset_in_ready",  160'(in_ready),  160'(1));
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].din);
            #1;
            check($sformatf("tbl%0d_in_ready", i), 160'(in_ready), 160'(1));
            @(negedge clk);
            check($sformatf("tbl%0d_out_valid", i), 160'(out_valid), 160'(tbl[i].exp_ov));
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_out_data", i),  160'(out_data),  160'(tbl[i].exp_data));
                check($sformatf("tbl%0d_out_count", i), 160'(out_count), 160'(tbl[i].exp_cnt));
                check($sformatf("tbl%0d_out_sat", i),   160'(out_sat),   160'(0));
            end
        end

        // Backpressure: a pending result must freeze the input completely.
        drive(0, 0, 0, '0);
        @(negedge clk);
        drive(1, 1, 1, din4(50, 0, 0, 0));
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_pending_valid", 160'(out_valid), 160'(1));
        drive(1, 1, 0, din4(1, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d_in_ready", i), 160'(in_ready), 160'(0));
            check($sformatf("bp%0d_out_data", i), 160'(out_data), 160'(dout4(50, 0, 0, 0)));
            check($sformatf("bp%0d_out_valid", i), 160'(out_valid), 160'(1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 160'(in_ready), 160'(1));
        @(negedge clk);
        check("bp_consumed_valid", 160'(out_valid), 160'(0));
        drive(1, 0, 0, din4(2, 0, 0, 0));
        @(negedge clk);
        drive(1, 0, 1, din4(3, 0, 0, 0));
        @(negedge clk);
        drive(0, 0, 0, '0);
        check("bp_resume_valid", 160'(out_valid), 160'(1));
        check("bp_resume_data",  160'(out_data),  160'(dout4(6, 0, 0, 0)));
        check("bp_resume_count", 160'(out_count), 160'(3));

        // 300-beat frame of lane0 max positive: saturates or wraps.
        for (int i = 0; i < 300; i++) begin
            drive(1, (i == 0), (i == 299), din4(32'sh7FFF_FFFF, 0, 0, 0));
            @(negedge clk);
        end
        drive(0, 0, 0, '0);
`ifdef ACC_SAT_EN
        exp_lane0 = 40'h7F_FFFF_FFFF;
        exp_sat   = 4'b0001;
`else
        wide      = 64'd300 * 64'h7FFF_FFFF;
        exp_lane0 = wide[DWA-1:0];
        exp_sat   = 4'b0000;
`endif
        check("long_valid", 160'(out_valid), 160'(1));
        check("long_data",  160'(out_data),  160'({120'd0, exp_lane0}));
        check("long_count", 160'(out_count), 160'(300));
        check("long_sat",   160'(out_sat),   160'(exp_sat));

        // Asynchronous reset with a pending result.
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("areset_out_valid", 160'(out_valid), 160'(0));
        check("areset_out_data",  160'(out_data),  160'(0));
        check("areset_out_count", 160'(out_count), 160'(0));
        check("areset_out_sat",   160'(out_sat),   160'(0));
        check("areset_in_ready",  160'(in_ready),  160'(1));
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Asynchronous reset inside an open frame drops the partial sum.
        drive(1, 1, 0, din4(50, 9, 0, 0));
        @(negedge clk);
        drive(0, 0, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("areset2_out_valid", 160'(out_valid), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, din4(1, 0, 0, 0));
        @(negedge clk);
        drive(1, 0, 1, din4(1, 0, 0, 0));
        @(negedge clk);
        drive(0, 0, 0, '0);
        check("post_reset_valid", 160'(out_valid), 160'(1));
        check("post_reset_data",  160'(out_data),  160'(dout4(2, 0, 0, 0)));
        check("post_reset_count", 160'(out_count), 160'(2));
        @(negedge clk);
        check("post_reset_drop",  160'(out_valid), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
